// File: rtl/sdspi_card_emu_if.sv
// SPI link plus status outputs of the SD card emulator; the host side drives sclk/cs/mosi.
interface sdspi_card_emu_if;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic        miso;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        card_idle;
    logic [31:0] blocks_sent;

    modport master (
        output sclk, cs, mosi,
        input  miso, cmd_valid, cmd_index, cmd_arg, card_idle, blocks_sent
    );

    modport slave (
        input  sclk, cs, mosi,
        output miso, cmd_valid, cmd_index, cmd_arg, card_idle, blocks_sent
    );
endinterface

// File: rtl/sdspi_card_emu.sv
// SPI-mode SD card responder: decodes command frames, answers R1/R3/R7 and streams generated read blocks.
module sdspi_card_emu #(
    parameter int INIT_RETRIES = 2,
    parameter int NCR_BYTES    = 1,
    parameter int NAC_BYTES    = 2,
    parameter int BLOCK_BYTES  = 512
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    sdspi_card_emu_if.slave bus
);
    typedef enum logic [2:0] {RX_CMD, NCR, RESP, NAC, TOKEN, DATA, CRC, STOP} state_t;

    localparam logic [7:0]  RETRIES  = 8'(INIT_RETRIES);
    localparam logic [15:0] NCR_CNT0 = 16'(NCR_BYTES - 2);
    localparam logic [15:0] NAC_CNT0 = 16'(NAC_BYTES - 1);
    localparam logic [15:0] BLK_LAST = 16'(BLOCK_BYTES - 1);

    logic [2:0]      sclk_sync_q;
    logic [1:0]      cs_sync_q, mosi_sync_q;
    logic [2:0]      bit_cnt_q;
    logic [6:0]      rx_sr_q;
    logic [7:0]      tx_sr_q;
    logic            miso_q;
    logic            frm_active_q;
    logic [2:0]      frm_cnt_q;
    logic [5:0]      frm_idx_q;
    logic [31:0]     frm_arg_q;
    state_t          state_q;
    logic [15:0]     cnt_q;
    logic [4:0][7:0] resp_q;
    logic [2:0]      resp_last_q;
    logic            xfer_q, multi_q, blk_pend_q, acmd_q, card_idle_q, cmd_valid_q;
    logic [31:0]     addr_q, blocks_q, cmd_arg_q;
    logic [7:0]      retry_q;
    logic [5:0]      cmd_index_q;

    logic            sclk_rise, sclk_fall, byte_done, frame_done, in_xfer, cmd_accept;
    logic [7:0]      rx_byte;
    logic [4:0][7:0] resp_d;
    logic [2:0]      resp_last_d;
    logic            start_xfer_d, acmd_arm_d, retry_inc_d, idle_set_d, idle_clr_d;

    assign sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2] & ~cs_sync_q[1];
    assign sclk_fall  = ~sclk_sync_q[1] & sclk_sync_q[2] & ~cs_sync_q[1];
    assign byte_done  = sclk_rise && (bit_cnt_q == 3'd7);
    assign rx_byte    = {rx_sr_q, mosi_sync_q[1]};
    assign frame_done = byte_done && frm_active_q && (frm_cnt_q == 3'd5);
    assign in_xfer    = (state_q == NAC) || (state_q == TOKEN) || (state_q == DATA) || (state_q == CRC);
    // Mid-transfer only CMD12 is acted on; every other frame is silently dropped.
    assign cmd_accept = frame_done && ((state_q == RX_CMD) || (in_xfer && frm_idx_q == 6'd12));

    always_comb begin
        resp_d       = {5{8'hFF}};
        resp_d[0]    = {7'b0, card_idle_q};
        resp_last_d  = 3'd0;
        start_xfer_d = 1'b0;
        acmd_arm_d   = 1'b0;
        retry_inc_d  = 1'b0;
        idle_set_d   = 1'b0;
        idle_clr_d   = 1'b0;
        case (frm_idx_q)
            6'd0: begin
                resp_d[0]  = 8'h01;
                idle_set_d = 1'b1;
            end
            6'd8: begin
                resp_d      = {frm_arg_q[7:0], 8'h01, 8'h00, 8'h00, 8'h01};
                resp_last_d = 3'd4;
            end
            6'd55: acmd_arm_d = 1'b1;
            6'd41: begin
                if (!acmd_q) begin
                    resp_d[0] = {5'b0, 1'b1, 1'b0, card_idle_q};
                end else if (retry_q < RETRIES) begin
                    resp_d[0]   = 8'h01;
                    retry_inc_d = 1'b1;
                end else begin
                    resp_d[0]  = 8'h00;
                    idle_clr_d = 1'b1;
                end
            end
            6'd58: begin
                resp_d      = {8'h00, 8'h80, 8'hFF, 8'hC0, {7'b0, card_idle_q}};
                resp_last_d = 3'd4;
            end
            6'd12, 6'd16: ;
            6'd17, 6'd18: begin
                resp_d[0]    = card_idle_q ? 8'h05 : 8'h00;
                start_xfer_d = ~card_idle_q;
            end
            default: resp_d[0] = {5'b0, 1'b1, 1'b0, card_idle_q};
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= 2'b11;
            mosi_sync_q  <= 2'b11;
            bit_cnt_q    <= '0;
            rx_sr_q      <= '0;
            tx_sr_q      <= 8'hFF;
            miso_q       <= 1'b1;
            frm_active_q <= 1'b0;
            frm_cnt_q    <= '0;
            frm_idx_q    <= '0;
            frm_arg_q    <= '0;
            state_q      <= RX_CMD;
            cnt_q        <= '0;
            resp_q       <= '0;
            resp_last_q  <= '0;
            xfer_q       <= 1'b0;
            multi_q      <= 1'b0;
            blk_pend_q   <= 1'b0;
            acmd_q       <= 1'b0;
            card_idle_q  <= 1'b1;
            cmd_valid_q  <= 1'b0;
            addr_q       <= '0;
            blocks_q     <= '0;
            cmd_arg_q    <= '0;
            cmd_index_q  <= '0;
            retry_q      <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], bus.sclk};
            cs_sync_q   <= {cs_sync_q[0], bus.cs};
            mosi_sync_q <= {mosi_sync_q[0], bus.mosi};
            cmd_valid_q <= 1'b0;
            if (cs_sync_q[1]) begin
                bit_cnt_q    <= '0;
                tx_sr_q      <= 8'hFF;
                miso_q       <= 1'b1;
                frm_active_q <= 1'b0;
                state_q      <= RX_CMD;
                blk_pend_q   <= 1'b0;
            end else begin
                if (sclk_fall) begin
                    miso_q  <= tx_sr_q[7];
                    tx_sr_q <= {tx_sr_q[6:0], 1'b1};
                end
                if (sclk_rise) begin
                    rx_sr_q   <= rx_byte[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                if (byte_done) begin
                    if (!frm_active_q) begin
                        if (rx_byte[7:6] == 2'b01) begin
                            frm_active_q <= 1'b1;
                            frm_cnt_q    <= 3'd1;
                            frm_idx_q    <= rx_byte[5:0];
                        end
                    end else begin
                        if (frm_cnt_q == 3'd5) frm_active_q <= 1'b0;
                        else                   frm_arg_q    <= {frm_arg_q[23:0], rx_byte};
                        frm_cnt_q <= frm_cnt_q + 3'd1;
                    end
                    // A block counts once its last CRC byte has actually gone out.
                    if (blk_pend_q) begin
                        blocks_q   <= blocks_q + 32'd1;
                        blk_pend_q <= 1'b0;
                    end
                    if (cmd_accept) begin
                        cmd_valid_q <= 1'b1;
                        cmd_index_q <= frm_idx_q;
                        cmd_arg_q   <= frm_arg_q;
                    end
                    case (state_q)
                        RX_CMD: begin
                            tx_sr_q <= 8'hFF;
                            if (cmd_accept) begin
                                resp_q      <= resp_d;
                                resp_last_q <= resp_last_d;
                                xfer_q      <= start_xfer_d;
                                multi_q     <= (frm_idx_q == 6'd18);
                                addr_q      <= frm_arg_q;
                                acmd_q      <= acmd_arm_d;
                                if (idle_set_d) begin
                                    card_idle_q <= 1'b1;
                                    retry_q     <= '0;
                                end
                                if (retry_inc_d) retry_q <= retry_q + 8'd1;
                                if (idle_clr_d) card_idle_q <= 1'b0;
                                if (NCR_BYTES > 1) begin
                                    state_q <= NCR;
                                    cnt_q   <= NCR_CNT0;
                                end else begin
                                    state_q <= RESP;
                                    cnt_q   <= '0;
                                end
                            end
                        end
                        NCR: begin
                            tx_sr_q <= 8'hFF;
                            if (cnt_q == '0) state_q <= RESP;
                            else             cnt_q   <= cnt_q - 16'd1;
                        end
                        RESP: begin
                            tx_sr_q <= resp_q[cnt_q[2:0]];
                            if (cnt_q[2:0] == resp_last_q) begin
                                state_q <= xfer_q ? NAC : RX_CMD;
                                cnt_q   <= NAC_CNT0;
                            end else begin
                                cnt_q <= cnt_q + 16'd1;
                            end
                        end
                        NAC: begin
                            tx_sr_q <= 8'hFF;
                            if (cnt_q == '0) state_q <= TOKEN;
                            else             cnt_q   <= cnt_q - 16'd1;
                        end
                        TOKEN: begin
                            tx_sr_q <= 8'hFE;
                            state_q <= DATA;
                            cnt_q   <= '0;
                        end
                        DATA: begin
                            tx_sr_q <= addr_q[7:0] ^ cnt_q[7:0];
                            if (cnt_q == BLK_LAST) begin
                                state_q <= CRC;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 16'd1;
                            end
                        end
                        CRC: begin
                            tx_sr_q <= 8'hFF;
                            if (cnt_q[0]) begin
                                blk_pend_q <= 1'b1;
                                if (multi_q) begin
                                    state_q <= NAC;
                                    cnt_q   <= NAC_CNT0;
                                    addr_q  <= addr_q + 32'd1;
                                end else begin
                                    state_q <= RX_CMD;
                                end
                            end else begin
                                cnt_q <= 16'd1;
                            end
                        end
                        STOP: begin
                            tx_sr_q <= 8'h00;
                            state_q <= RX_CMD;
                        end
                        default: state_q <= RX_CMD;
                    endcase
                    // CMD12 inside a transfer: one stuff byte now, R1 0x00 from STOP next.
                    if (in_xfer && cmd_accept) begin
                        tx_sr_q    <= 8'hFF;
                        state_q    <= STOP;
                        blk_pend_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.miso        = miso_q;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_index   = cmd_index_q;
    assign bus.cmd_arg     = cmd_arg_q;
    assign bus.card_idle   = card_idle_q;
    assign bus.blocks_sent = blocks_q;
endmodule

// File: tb/tb_sdspi_card_emu.sv
// Directed bench for sdspi_card_emu: command/response table followed by read-transfer sequences.
module tb_sdspi_card_emu;
    localparam int HALF = 6;
    localparam int BLK  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdspi_card_emu_if bus();

    sdspi_card_emu #(
        .INIT_RETRIES(2),
        .NCR_BYTES(1),
        .NAC_BYTES(2),
        .BLOCK_BYTES(BLK)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cnt = 0;

    always @(posedge clk) if (bus.cmd_valid === 1'b1) valid_cnt <= valid_cnt + 1;

    typedef struct {
        string       name;
        logic [47:0] frame;
        int          nresp;
        logic [39:0] resp;
        logic        exp_idle;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %h", name, act);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            bus.mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = bus.miso;
            bus.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [47:0] f);
        logic [7:0] dummy;
        for (int k = 0; k < 6; k++) spi_byte(f[47 - 8*k -: 8], dummy);
    endtask

    task automatic expect_byte(input string name, input logic [7:0] exp);
        logic [7:0] b;
        spi_byte(8'hFF, b);
        check(name, {24'h0, b}, {24'h0, exp});
    endtask

    task automatic expect_block(input logic [7:0] addr);
        expect_byte("nac0", 8'hFF);
        expect_byte("nac1", 8'hFF);
        expect_byte("token", 8'hFE);
        for (int i = 0; i < BLK; i++) expect_byte($sformatf("data%0d", i), addr ^ 8'(i));
        expect_byte("crc0", 8'hFF);
        expect_byte("crc1", 8'hFF);
    endtask

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        logic [7:0] b;
        logic [47:0] stop_frame;

        vecs[0]  = '{"cmd0",        48'h40_00000000_95, 1, {8'h01, 32'h0}, 1'b1};
        vecs[1]  = '{"cmd8",        48'h48_000001AA_87, 5, 40'h01_00_00_01_AA, 1'b1};
        vecs[2]  = '{"cmd58",       48'h7A_00000000_FF, 5, 40'h01_C0_FF_80_00, 1'b1};
        vecs[3]  = '{"cmd17_idle",  48'h51_00000005_FF, 1, {8'h05, 32'h0}, 1'b1};
        vecs[4]  = '{"cmd55_a",     48'h77_00000000_FF, 1, {8'h01, 32'h0}, 1'b1};
        vecs[5]  = '{"acmd41_a",    48'h69_40000000_FF, 1, {8'h01, 32'h0}, 1'b1};
        vecs[6]  = '{"cmd55_b",     48'h77_00000000_FF, 1, {8'h01, 32'h0}, 1'b1};
        vecs[7]  = '{"acmd41_b",    48'h69_40000000_FF, 1, {8'h01, 32'h0}, 1'b1};
        vecs[8]  = '{"cmd55_c",     48'h77_00000000_FF, 1, {8'h01, 32'h0}, 1'b1};
        vecs[9]  = '{"acmd41_c",    48'h69_40000000_FF, 1, {8'h00, 32'h0}, 1'b0};
        vecs[10] = '{"cmd41_plain", 48'h69_40000000_FF, 1, {8'h04, 32'h0}, 1'b0};
        vecs[11] = '{"cmd16",       48'h50_00000200_FF, 1, {8'h00, 32'h0}, 1'b0};
        vecs[12] = '{"cmd12_idle",  48'h4C_00000000_FF, 1, {8'h00, 32'h0}, 1'b0};
        vecs[13] = '{"cmd5_illegal",48'h45_00000000_FF, 1, {8'h04, 32'h0}, 1'b0};

        bus.sclk = 1'b0;
        bus.cs   = 1'b1;
        bus.mosi = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_miso",      {31'h0, bus.miso}, 32'h1);
        check("rst_cmd_valid", {31'h0, bus.cmd_valid}, 32'h0);
        check("rst_cmd_index", {26'h0, bus.cmd_index}, 32'h0);
        check("rst_cmd_arg",   bus.cmd_arg, 32'h0);
        check("rst_card_idle", {31'h0, bus.card_idle}, 32'h1);
        check("rst_blocks",    bus.blocks_sent, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        bus.cs = 1'b0;
        repeat (10) @(negedge clk);
        expect_byte("preamble", 8'hFF);

        for (int n = 0; n < 14; n++) begin
            v0 = valid_cnt;
            send_frame(vecs[n].frame);
            check({vecs[n].name, "_valid"}, 32'(valid_cnt - v0), 32'd1);
            check({vecs[n].name, "_index"}, {26'h0, bus.cmd_index}, {26'h0, vecs[n].frame[45:40]});
            check({vecs[n].name, "_arg"}, bus.cmd_arg, vecs[n].frame[39:8]);
            expect_byte({vecs[n].name, "_ncr"}, 8'hFF);
            for (int j = 0; j < vecs[n].nresp; j++)
                expect_byte($sformatf("%s_r%0d", vecs[n].name, j), vecs[n].resp[39 - 8*j -: 8]);
            check({vecs[n].name, "_idle"}, {31'h0, bus.card_idle}, {31'h0, vecs[n].exp_idle});
        end

        // Single-block read at address 5.
        send_frame(48'h51_00000005_FF);
        expect_byte("t4_ncr", 8'hFF);
        expect_byte("t4_r1", 8'h00);
        expect_block(8'h05);
        expect_byte("t4_tail0", 8'hFF);
        expect_byte("t4_tail1", 8'hFF);
        check("t4_blocks", bus.blocks_sent, 32'd1);

        // Multi-block read from 0x10, stopped by CMD12 part-way through the third block.
        send_frame(48'h52_00000010_FF);
        expect_byte("t5_ncr", 8'hFF);
        expect_byte("t5_r1", 8'h00);
        expect_block(8'h10);
        expect_block(8'h11);
        expect_byte("t5_nac0", 8'hFF);
        expect_byte("t5_nac1", 8'hFF);
        expect_byte("t5_token", 8'hFE);
        for (int i = 0; i < 4; i++) expect_byte($sformatf("t5_d%0d", i), 8'h12 ^ 8'(i));
        stop_frame = 48'h4C_00000000_61;
        v0 = valid_cnt;
        for (int k = 0; k < 6; k++) begin
            spi_byte(stop_frame[47 - 8*k -: 8], b);
            check($sformatf("t5_d%0d", 4 + k), {24'h0, b}, {24'h0, 8'h12 ^ 8'(4 + k)});
        end
        check("t5_stop_valid", 32'(valid_cnt - v0), 32'd1);
        check("t5_stop_index", {26'h0, bus.cmd_index}, 32'd12);
        expect_byte("t5_stuff", 8'hFF);
        expect_byte("t5_stop_r1", 8'h00);
        expect_byte("t5_tail0", 8'hFF);
        expect_byte("t5_tail1", 8'hFF);
        check("t5_blocks", bus.blocks_sent, 32'd3);

        // cs raised mid-block, then a clean restart of the same read.
        send_frame(48'h51_00000007_FF);
        expect_byte("t6_ncr", 8'hFF);
        expect_byte("t6_r1", 8'h00);
        expect_byte("t6_nac0", 8'hFF);
        expect_byte("t6_nac1", 8'hFF);
        expect_byte("t6_token", 8'hFE);
        for (int i = 0; i < 3; i++) expect_byte($sformatf("t6_d%0d", i), 8'h07 ^ 8'(i));
        bus.cs = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_miso_cs_high", {31'h0, bus.miso}, 32'h1);
        check("t6_blocks_abort", bus.blocks_sent, 32'd3);
        check("t6_idle_kept", {31'h0, bus.card_idle}, 32'h0);
        bus.cs = 1'b0;
        repeat (10) @(negedge clk);
        send_frame(48'h51_00000007_FF);
        expect_byte("t6b_ncr", 8'hFF);
        expect_byte("t6b_r1", 8'h00);
        expect_block(8'h07);
        expect_byte("t6b_tail0", 8'hFF);
        expect_byte("t6b_tail1", 8'hFF);
        check("t6_blocks", bus.blocks_sent, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
